// File: rtl/ring_noc_pkg.sv
// Shared constants and helpers for the CMP ring router datapath.
package ring_noc_pkg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned VC_BIT  = 63;
    localparam int unsigned HOP_LSB = 18;
    localparam int unsigned HOP_MSB = 25;
    localparam int unsigned CNT_W   = 16;

    localparam int unsigned REQ_RING = 0;
    localparam int unsigned REQ_PE   = 1;

    localparam logic VC_EVEN = 1'b0;
    localparam logic VC_ODD  = 1'b1;

    typedef logic [DATA_W-1:0] pkt_t;

    // One hop consumed per ring traversal: the hop field is halved in place.
    function automatic pkt_t hop_rewrite(input pkt_t pkt);
        pkt_t res;
        res = pkt;
        res[HOP_MSB:HOP_LSB] = pkt[HOP_MSB:HOP_LSB] >> 1;
        return res;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the loser on every grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_gnt_c
);

    logic r_ptr;

    always_comb begin
        o_gnt_c = i_req;
        if (i_req == 2'b11) begin
            o_gnt_c = r_ptr ? 2'b10 : 2'b01;
        end
    end

    // Granting requester 0 hands priority to requester 1 and vice versa.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_update) begin
            r_ptr <= o_gnt_c[0];
        end
    end

endmodule

// File: rtl/ring_output_arbiter.sv
// Per-direction output scheduler: ring/PE arbitration into even/odd VC buffers,
// drained by polarity. Grant counters are built only with RING_ARB_STATS_EN.
module ring_output_arbiter
    import ring_noc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ring_req,
    input  logic [DATA_W-1:0] ring_data,
    output logic              ring_gnt,
    input  logic              pe_req,
    input  logic [DATA_W-1:0] pe_data,
    output logic              pe_gnt,
    output logic              so,
    output logic [DATA_W-1:0] do_data,
    input  logic              ro,
    output logic              polarity,
    output logic [CNT_W-1:0]  ring_gnt_cnt,
    output logic [CNT_W-1:0]  pe_gnt_cnt
);

    logic       r_pol;
    logic [1:0] r_full;
    pkt_t       r_buf [2];
    logic       r_so;
    pkt_t       r_do_data;

    logic       w_fill_vc;
    logic       w_ring_ok;
    logic       w_pe_ok;
    logic [1:0] w_req_even;
    logic [1:0] w_req_odd;
    logic [1:0] w_gnt_even;
    logic [1:0] w_gnt_odd;
    logic [1:0] w_gnt;
    logic [1:0] w_full_nxt;
    pkt_t       w_buf_nxt [2];
    pkt_t       w_wr_data;

    // Only the VC not on the link is writable, and only when it is empty.
    assign w_fill_vc = ~r_pol;
    assign w_ring_ok = reset & ring_req & (ring_data[VC_BIT] == w_fill_vc) & ~r_full[w_fill_vc];
    assign w_pe_ok   = reset & pe_req & (pe_data[VC_BIT] == w_fill_vc) & ~r_full[w_fill_vc];

    assign w_req_even = (w_fill_vc == VC_EVEN) ? {w_pe_ok, w_ring_ok} : 2'b00;
    assign w_req_odd  = (w_fill_vc == VC_ODD)  ? {w_pe_ok, w_ring_ok} : 2'b00;

    rr_arb2 u_arb_even (
        .clk      (clk),
        .i_rst_n  (reset),
        .i_req    (w_req_even),
        .i_update (|w_gnt_even),
        .o_gnt_c  (w_gnt_even)
    );

    rr_arb2 u_arb_odd (
        .clk      (clk),
        .i_rst_n  (reset),
        .i_req    (w_req_odd),
        .i_update (|w_gnt_odd),
        .o_gnt_c  (w_gnt_odd)
    );

    assign w_gnt     = w_gnt_even | w_gnt_odd;
    assign ring_gnt  = w_gnt[REQ_RING];
    assign pe_gnt    = w_gnt[REQ_PE];
    assign w_wr_data = w_gnt[REQ_RING] ? hop_rewrite(ring_data) : pe_data;

    // Drain and fill always target different buffers, so they never collide.
    always_comb begin
        w_full_nxt = r_full;
        w_buf_nxt  = r_buf;
        if (r_so && ro) begin
            w_full_nxt[r_pol] = 1'b0;
        end
        if (|w_gnt) begin
            w_full_nxt[w_fill_vc] = 1'b1;
            w_buf_nxt[w_fill_vc]  = w_wr_data;
        end
    end

    // Link outputs are registered from the buffer that owns the next phase.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pol     <= 1'b0;
            r_full    <= 2'b00;
            r_buf[0]  <= '0;
            r_buf[1]  <= '0;
            r_so      <= 1'b0;
            r_do_data <= '0;
        end else begin
            r_pol     <= w_fill_vc;
            r_full    <= w_full_nxt;
            r_buf     <= w_buf_nxt;
            r_so      <= w_full_nxt[w_fill_vc];
            r_do_data <= w_full_nxt[w_fill_vc] ? w_buf_nxt[w_fill_vc] : '0;
        end
    end

    assign so       = r_so;
    assign do_data  = r_do_data;
    assign polarity = r_pol;

`ifdef RING_ARB_STATS_EN
    logic [CNT_W-1:0] r_ring_cnt;
    logic [CNT_W-1:0] r_pe_cnt;

    // Saturating grant counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ring_cnt <= '0;
            r_pe_cnt   <= '0;
        end else begin
            if (ring_gnt && (r_ring_cnt != '1)) begin
                r_ring_cnt <= r_ring_cnt + CNT_W'(1);
            end
            if (pe_gnt && (r_pe_cnt != '1)) begin
                r_pe_cnt <= r_pe_cnt + CNT_W'(1);
            end
        end
    end

    assign ring_gnt_cnt = r_ring_cnt;
    assign pe_gnt_cnt   = r_pe_cnt;
`else
    assign ring_gnt_cnt = '0;
    assign pe_gnt_cnt   = '0;
`endif

endmodule

// File: doc/ring_output_arbiter.md
Name: ring_output_arbiter

Overview:
- Per-output-link scheduler for the CMP ring router (cw or ccw output).
- Shares one outgoing link between two requesters: the ring pass-through input (req 0) and the local PE injection (req 1).
- Holds a one-entry output buffer per virtual channel (even, odd).
- Sequences link transmission by the router's even/odd polarity. Instantiated once per ring direction.

Parameters:
- DATA_W, 64, packet width.
- VC_BIT, 63, packet bit selecting the virtual channel (0 = even, 1 = odd).
- HOP_LSB, 18, low bit of the hop field.
- HOP_MSB, 25, high bit of the hop field.

Ports:
- clk  in  1  router clock.
- reset  in  1  synchronous, active-low reset.
- ring_req  in  1  ring input has a packet.
- ring_data  in  DATA_W  ring input packet.
- ring_gnt  out  1  ring packet accepted this cycle.
- pe_req  in  1  PE has a packet to inject.
- pe_data  in  DATA_W  PE packet.
- pe_gnt  out  1  PE packet accepted this cycle.
- so  out  1  link send strobe.
- do_data  out  DATA_W  link data.
- ro  in  1  downstream ready.
- polarity  out  1  current phase (0 = even, 1 = odd).
- ring_gnt_cnt  out  16  ring grant counter (optional feature).
- pe_gnt_cnt  out  16  PE grant counter (optional feature).

Behaviour:
- Reset:
  - Clock is clk; reset is synchronous and active-low, sampled only on the rising clk edge.
  - While reset is low: ring_gnt = pe_gnt = 0 combinationally.
  - At the edge with reset low: both buffers empty, polarity = 0, both round-robin pointers = 0 (ring favoured), counters = 0, so = 0, do_data = 0.
  - A reset asserted mid-operation discards buffered packets; nothing is transmitted afterwards.
- Polarity: toggles every cycle after reset. The first post-reset cycle is even.
- Link phase (buffer V where V == polarity):
  - so = full[V]; do_data = buf[V] when so is 1, else 0.
  - Transfer occurs when so && ro. buf[V] becomes empty at that edge.
  - If ro = 0, the packet is held until the next V phase.
- Fill phase (buffer V where V != polarity):
  - Buffer V may be written only in this phase, so write and drain never coincide.
  - A requester targets V = data[VC_BIT].
  - A grant requires full[V] = 0 at the start of the cycle. There is no bypass.
- Grants are combinational from registered state plus req/data. The write happens at the edge. The requester holds req and data stable until granted.
- Contention (both requesters target the same writable VC):
  - Grant goes to ptr[V] (0 = ring, 1 = pe).
  - After any grant on V, ptr[V] becomes the index of the non-granted requester.
  - A single uncontested grant also updates ptr[V] to the other requester.
- At most one buffer is writable per cycle, so at most one grant per cycle.
- Requests targeting the VC currently in link phase wait; no grant.
- Hop rewrite: ring-granted packets are stored with data[HOP_MSB:HOP_LSB] shifted right by one bit. PE packets are stored unmodified.
- Latency: a granted packet appears on the link at the earliest in the next cycle, which is its VC's link phase.

Optional Feature:
- Macro: RING_ARB_STATS_EN.
- Defined: ring_gnt_cnt and pe_gnt_cnt increment on each respective grant, saturating at 16'hFFFF, cleared by reset.
- Undefined: no counter registers; both ports are driven constant 0.

Decomposition:
- Shared package ring_noc_pkg holds:
  - DATA_W, VC_BIT, HOP_LSB, HOP_MSB constants.
  - Requester index constants REQ_RING = 0, REQ_PE = 1.
  - VC constants VC_EVEN = 0, VC_ODD = 1.
- One sub-module: rr_arb2. It is a 2-way round-robin arbiter with a pointer register and an update-on-grant input, and is instantiated per VC.

Test Plan:
- Reset then idle 10 cycles: polarity toggles 0,1,0,...; so = 0; do_data = 0; grants = 0.
- Ring packet, VC even, hop 8'h04, req in cycle 1 (odd phase):
  - ring_gnt = 1 in cycle 1.
  - Cycle 2 (even): so = 1, do_data has hop 8'h02.
  - With ro = 1 the buffer empties.
- Ring and PE both target VC odd during an even phase:
  - The ring is granted first.
  - The PE is granted in the next even phase after the odd buffer drains.
  - The pointer then favours the ring again.
- ro held 0 for 6 cycles with the even buffer full:
  - so = 1 only in even cycles, and do_data is stable.
  - A PE request to VC even is not granted until after the drain.
- Reset driven low mid-transfer with both buffers full: next cycle so = 0, polarity = 0, buffers empty, no stale packet emitted.
- With RING_ARB_STATS_EN defined: 3 ring grants and 2 PE grants give ring_gnt_cnt = 3 and pe_gnt_cnt = 2. Without the macro both read 0.
